pipe_redirect_ctrl: RTL
=======================

// Module: pipe_redirect_ctrl
// PURPOSE
//   Pipeline sequencing controller for the 5-stage RV32I core. Consumes the EX-stage NPC select
//   from the branch judge, the ID-stage load-use hazard and the EX-stage halt (ecall/ebreak).
//   Drives the PC mux select, PC/IF-ID write enables and IF-ID/ID-EX flushes, inserts optional
//   post-redirect squash cycles, latches halt, and keeps redirect/stall performance counters.
// PARAMETERS
//   EXTRA_BUBBLES  0   extra IF-ID squash cycles after each redirect (0..7; fetch BRAM latency)
//   CNT_W          32  width of redirect_cnt and stall_cnt
// PORTS
//   clk           in   1      core clock, rising edge
//   rst           in   1      synchronous, active-high reset
//   ex_valid      in   1      EX stage holds a real (non-bubble) instruction
//   npc_sel       in   2      branch judge NPC select: 00 PC+4, 01 branch, 10 jump(jal/jalr), 11 auipc
//   load_use      in   1      ID instruction needs rd of an EX-stage load
//   halt_req      in   1      EX instruction is ecall/ebreak
//   pc_sel        out  2      PC mux select to fetch
//   pc_we         out  1      PC register write enable
//   ifid_we       out  1      IF-ID register write enable
//   ifid_flush    out  1      clear IF-ID to bubble on next edge
//   idex_flush    out  1      clear ID-EX to bubble on next edge
//   halted        out  1      core halted (sticky until rst)
//   redirect_cnt  out  CNT_W  count of accepted redirects
//   stall_cnt     out  CNT_W  count of load-use stall cycles
// BEHAVIOUR
//   States: RUN, SQUASH, HALT. Reset -> RUN, squash counter 0, halted 0, both counters 0.
//   While rst=1 (combinational outputs): pc_sel=00, pc_we=0, ifid_we=0, ifid_flush=1, idex_flush=1.
//   redirect = (state==RUN) & ex_valid & (npc_sel!=00). 11 is a redirect (PC gets auipc path).
//   stall    = (state==RUN) & load_use & ~redirect & ~halt_acc.
//   halt_acc = (state==RUN) & ex_valid & halt_req & ~redirect.
//   RUN outputs, zero latency (combinational):
//     redirect: pc_sel=npc_sel, pc_we=1, ifid_we=1, ifid_flush=1, idex_flush=1.
//     stall:    pc_sel=00, pc_we=0, ifid_we=0, ifid_flush=0, idex_flush=1 (bubble into EX).
//     halt_acc: pc_sel=00, pc_we=0, ifid_we=0, ifid_flush=1, idex_flush=1.
//     else:     pc_sel=00, pc_we=1, ifid_we=1, flushes 0.
//   Priority: redirect > halt_acc > stall (wrong-path ID instruction must not stall the branch).
//   RUN transitions: redirect & EXTRA_BUBBLES>0 -> SQUASH, load squash counter=EXTRA_BUBBLES;
//     halt_acc -> HALT; else stay RUN.
//   SQUASH: pc_sel=00, pc_we=1, ifid_we=1, ifid_flush=1, idex_flush=1; npc_sel, load_use,
//     halt_req ignored (wrong path). Counter decrements each cycle; leave to RUN on the cycle
//     the counter is 1 (exactly EXTRA_BUBBLES SQUASH cycles).
//   HALT: pc_we=0, ifid_we=0, ifid_flush=1, idex_flush=1, pc_sel=00, halted=1; exits only on rst.
//   halted is registered: rises the cycle after halt_acc.
//   Counters: redirect_cnt +1 per redirect, stall_cnt +1 per stall cycle; registered, wrap modulo
//     2^CNT_W, never count in SQUASH/HALT or during rst.
//   Reset mid-SQUASH or in HALT returns to RUN next edge; counters cleared.
// TESTING
//   Straight-line: ex_valid=1, npc_sel=00 for 10 cycles -> pc_we=ifid_we=1, no flush, counters 0.
//   Taken beq (npc_sel=01), EXTRA_BUBBLES=0 -> same cycle pc_sel=01, both flushes=1; next cycle
//     RUN, redirect_cnt=1.
//   jal (10) + load_use same cycle -> redirect wins: pc_we=1, idex_flush=1, stall_cnt stays 0.
//   load_use 2 cycles, no branch -> pc_we=ifid_we=0, idex_flush=1 both cycles, stall_cnt=2.
//   EXTRA_BUBBLES=2: jalr (10) then npc_sel=01 next 2 cycles -> exactly 2 SQUASH cycles,
//     second branch ignored, redirect_cnt=1, RUN on 3rd cycle.
//   ecall (halt_req) with ex_valid -> halted=1 next cycle, pc_we=0 stays; rst=1 one cycle ->
//     RUN, halted=0, counters 0.

Source files
------------

// File: rtl/pipe_redirect_ctrl.sv
// Pipeline sequencing controller: turns EX-stage redirects, halts and ID-stage load-use hazards
// into PC/IF-ID/ID-EX control, with optional post-redirect squash cycles and perf counters.
module pipe_redirect_ctrl #(
  parameter int unsigned EXTRA_BUBBLES = 0,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [1:0]       npc_sel,
  input  logic             load_use,
  input  logic             halt_req,
  output logic [1:0]       pc_sel,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {StRun, StSquash, StHalt} state_e;

  state_e           state_q, state_d;
  logic [2:0]       sq_cnt_q, sq_cnt_d;
  logic [CNT_W-1:0] redirect_cnt_q, stall_cnt_q;
  logic             in_run, redirect, halt_acc, stall;

  assign in_run   = (state_q == StRun);
  assign redirect = in_run & ex_valid & (npc_sel != 2'b00);
  assign halt_acc = in_run & ex_valid & halt_req & ~redirect;
  // Wrong-path ID instruction behind a redirect or halt must not stall.
  assign stall    = in_run & load_use & ~redirect & ~halt_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StRun;
      sq_cnt_q       <= 3'd0;
      redirect_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sq_cnt_q <= sq_cnt_d;
      if (redirect) redirect_cnt_q <= redirect_cnt_q + CNT_W'(1);
      if (stall)    stall_cnt_q    <= stall_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    sq_cnt_d   = sq_cnt_q;
    pc_sel     = 2'b00;
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;

    case (state_q)
      StRun: begin
        if (redirect) begin
          pc_sel     = npc_sel;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          if (EXTRA_BUBBLES > 0) begin
            state_d  = StSquash;
            sq_cnt_d = 3'(EXTRA_BUBBLES);
          end
        end else if (halt_acc) begin
          pc_we      = 1'b0;
          ifid_we    = 1'b0;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          state_d    = StHalt;
        end else if (stall) begin
          pc_we      = 1'b0;
          ifid_we    = 1'b0;
          idex_flush = 1'b1;
        end
      end
      StSquash: begin
        // Fetch keeps advancing while the stale BRAM output is discarded.
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        sq_cnt_d   = sq_cnt_q - 3'd1;
        if (sq_cnt_q <= 3'd1) state_d = StRun;
      end
      StHalt: begin
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end
      default: state_d = StRun;
    endcase

    if (rst) begin
      pc_sel     = 2'b00;
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end
  end

  assign halted       = (state_q == StHalt);
  assign redirect_cnt = redirect_cnt_q;
  assign stall_cnt    = stall_cnt_q;

endmodule
